// File: rtl/alu_operand_ctrl.sv
// alu_operand_ctrl: latches operand A, operand B and opcode from shared switches on successive button presses, drives the ALU, and registers its result/carry.
// Ports: clk, rst_n (async active-low); sw[SIZE] shared switches; btnA/btnB/btnOP raw buttons;
//   alu_res[SIZE+1]/alu_carry from the ALU; alu_a/alu_b/alu_op registered ALU inputs;
//   res_q/carry_q captured result; valid = result matches current operands; state = FSM state.
// Optional ALU_CTRL_DEBOUNCE_EN: per-button debounce of DEB_CYCLES stable cycles; otherwise the
//   synchronized level feeds the edge detector directly.
module alu_operand_ctrl #(
  parameter int SIZE       = 8,
  parameter int OP_SIZE    = 6,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SIZE-1:0]   sw,
  input  logic              btnA,
  input  logic              btnB,
  input  logic              btnOP,
  input  logic [SIZE:0]     alu_res,
  input  logic              alu_carry,
  output logic [SIZE-1:0]   alu_a,
  output logic [SIZE-1:0]   alu_b,
  output logic [OP_SIZE-1:0] alu_op,
  output logic [SIZE:0]     res_q,
  output logic              carry_q,
  output logic              valid,
  output logic [1:0]        state
);
  typedef enum logic [1:0] {S_A = 2'd0, S_B = 2'd1, S_OP = 2'd2, S_DONE = 2'd3} state_t;
  state_t st, st_n;
  logic [2:0] btn, press;
  logic exec, ld_a, ld_b, ld_op;
  assign btn = {btnOP, btnB, btnA};
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic s1, s2, lvl, lvl_q;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) {s1, s2} <= 2'b00;
      else {s1, s2} <= {btn[i], s1};
`ifdef ALU_CTRL_DEBOUNCE_EN
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    // lvl only follows s2 after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        lvl <= 1'b0;
        cnt <= '0;
      end else if (s2 == lvl) cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        lvl <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
`else
    assign lvl = s2;
`endif
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) lvl_q <= 1'b0;
      else lvl_q <= lvl;
    assign press[i] = lvl & ~lvl_q;
  end
  // a new operation may start from S_DONE only once the result capture cycle is over
  always_comb begin
    ld_a  = press[0] && (st == S_A || (st == S_DONE && !exec));
    ld_b  = press[1] && st == S_B;
    ld_op = press[2] && st == S_OP;
    st_n  = ld_a ? S_B : ld_b ? S_OP : ld_op ? S_DONE : st;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st      <= S_A;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_op  <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      valid   <= 1'b0;
      exec    <= 1'b0;
    end else begin
      st <= st_n;
      if (ld_a) begin
        alu_a <= sw;
        valid <= 1'b0;
      end
      if (ld_b) alu_b <= sw;
      if (ld_op) begin
        alu_op <= sw[OP_SIZE-1:0];
        exec   <= 1'b1;
      end
      if (exec) begin
        res_q   <= alu_res;
        carry_q <= alu_carry;
        valid   <= 1'b1;
        exec    <= 1'b0;
      end
    end
  assign state = st;
endmodule
